// File: rtl/fabs_fadd_fcmp.sv
// Single-precision fadd / fabs / fcmp on AXI-Stream beats, flush-to-zero with round-to-nearest-even.
// Latency 2 cycles after acceptance; fully pipelined at one beat per cycle. FABS_FADD_FCMP_STATUS_EN adds m_axis_result_tuser.
// Backpressure: none; s_axis_tready is high whenever out of reset and results cannot be stalled.
module fabs_fadd_fcmp (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [1:0]  s_axis_op,
    input  logic [31:0] s_axis_a_tdata,
    input  logic [31:0] s_axis_b_tdata,
    input  logic [5:0]  s_axis_operation_tdata,
    output logic        m_axis_result_tvalid,
    output logic [31:0] m_axis_result_tdata
`ifdef FABS_FADD_FCMP_STATUS_EN
    ,
    output logic [2:0]  m_axis_result_tuser
`endif
);

    typedef enum logic [1:0] {
        OP_FADD = 2'b00,
        OP_FABS = 2'b01,
        OP_FCMP = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef struct packed {
        op_e         op;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  code;
    } beat_t;

    typedef struct packed {
        op_e         op;
        logic [31:0] dat;
        logic        nan;
        logic        inf;
        logic        inf_sgn;
        logic        zero_sgn;
        logic        sgn;
        logic [7:0]  exp;
        logic [27:0] sum;
    } mid_t;

    // ---------------- input capture ----------------
    logic  in_vld;
    beat_t in_dat;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            s_axis_tready <= 1'b0;
            in_vld        <= 1'b0;
        end else begin
            s_axis_tready <= 1'b1;
            in_vld        <= s_axis_tvalid && s_axis_tready;
        end
    end

    always_ff @(posedge aclk) begin
        if (s_axis_tvalid && s_axis_tready) begin
            in_dat.op   <= op_e'(s_axis_op);
            in_dat.a    <= s_axis_a_tdata;
            in_dat.b    <= s_axis_b_tdata;
            in_dat.code <= s_axis_operation_tdata;
        end
    end

    // ---------------- stage 1: classify, align, add, compare ----------------
    logic        a_nan, b_nan, a_inf, b_inf, a_zro, b_zro;
    logic [30:0] a_mag, b_mag;
    logic        a_neg, b_neg;
    logic [23:0] a_man, b_man, x_man, y_man;
    logic        swap, x_sgn, y_sgn;
    logic [7:0]  x_exp, y_exp, exp_diff;
    logic [4:0]  shift_amt;
    logic [53:0] y_wide;
    logic [26:0] y_al;
    logic        cmp_un, cmp_lt, cmp_eq, cmp_gt, cmp_bit;
    mid_t        mid_nxt;

    always_comb begin
        a_nan = (in_dat.a[30:23] == 8'hFF) && (in_dat.a[22:0] != 23'd0);
        b_nan = (in_dat.b[30:23] == 8'hFF) && (in_dat.b[22:0] != 23'd0);
        a_inf = (in_dat.a[30:23] == 8'hFF) && (in_dat.a[22:0] == 23'd0);
        b_inf = (in_dat.b[30:23] == 8'hFF) && (in_dat.b[22:0] == 23'd0);
        // Subnormals collapse to a signed zero before anything else looks at them
        a_zro = (in_dat.a[30:23] == 8'd0);
        b_zro = (in_dat.b[30:23] == 8'd0);
        a_mag = a_zro ? 31'd0 : in_dat.a[30:0];
        b_mag = b_zro ? 31'd0 : in_dat.b[30:0];
        a_neg = in_dat.a[31] && !a_zro;
        b_neg = in_dat.b[31] && !b_zro;
        a_man = a_zro ? 24'd0 : {1'b1, in_dat.a[22:0]};
        b_man = b_zro ? 24'd0 : {1'b1, in_dat.b[22:0]};

        swap  = (b_mag > a_mag);
        x_sgn = swap ? in_dat.b[31]     : in_dat.a[31];
        y_sgn = swap ? in_dat.a[31]     : in_dat.b[31];
        x_exp = swap ? in_dat.b[30:23]  : in_dat.a[30:23];
        y_exp = swap ? in_dat.a[30:23]  : in_dat.b[30:23];
        x_man = swap ? b_man : a_man;
        y_man = swap ? a_man : b_man;

        // Guard/round/sticky alignment; shifts past 27 leave only the sticky bit
        exp_diff  = x_exp - y_exp;
        shift_amt = (exp_diff > 8'd27) ? 5'd27 : exp_diff[4:0];
        y_wide    = {y_man, 30'd0} >> shift_amt;
        y_al      = {y_wide[53:28], y_wide[27] | (|y_wide[26:0])};

        cmp_un = a_nan || b_nan;
        cmp_eq = (a_mag == b_mag) && (a_neg == b_neg);
        cmp_lt = (a_neg && !b_neg) ||
                 (!a_neg && !b_neg && (a_mag < b_mag)) ||
                 (a_neg && b_neg && (a_mag > b_mag));
        cmp_gt = !cmp_lt && !cmp_eq;
        cmp_bit = 1'b0;
        if (in_dat.code[2:0] == 3'b100) begin
            case (in_dat.code[5:3])
                3'd0:    cmp_bit = cmp_un;
                3'd1:    cmp_bit = !cmp_un && cmp_lt;
                3'd2:    cmp_bit = !cmp_un && cmp_eq;
                3'd3:    cmp_bit = !cmp_un && (cmp_lt || cmp_eq);
                3'd4:    cmp_bit = !cmp_un && cmp_gt;
                3'd5:    cmp_bit = cmp_un || !cmp_eq;
                3'd6:    cmp_bit = !cmp_un && (cmp_gt || cmp_eq);
                default: cmp_bit = 1'b0;
            endcase
        end

        mid_nxt.op = in_dat.op;
        case (in_dat.op)
            OP_FABS: mid_nxt.dat = {1'b0, in_dat.a[30:0]};
            OP_FCMP: mid_nxt.dat = {31'd0, cmp_bit};
            default: mid_nxt.dat = 32'd0;
        endcase
        mid_nxt.nan      = a_nan || b_nan || (a_inf && b_inf && (in_dat.a[31] ^ in_dat.b[31]));
        mid_nxt.inf      = a_inf || b_inf;
        mid_nxt.inf_sgn  = a_inf ? in_dat.a[31] : in_dat.b[31];
        mid_nxt.zero_sgn = in_dat.a[31] && in_dat.b[31];
        mid_nxt.sgn      = x_sgn;
        mid_nxt.exp      = x_exp;
        mid_nxt.sum      = (x_sgn ^ y_sgn) ? ({1'b0, x_man, 3'b000} - {1'b0, y_al})
                                           : ({1'b0, x_man, 3'b000} + {1'b0, y_al});
    end

    logic mid_vld;
    mid_t mid;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            mid_vld <= 1'b0;
        end else begin
            mid_vld <= in_vld;
        end
    end

    always_ff @(posedge aclk) begin
        if (in_vld) begin
            mid <= mid_nxt;
        end
    end

    // ---------------- stage 2: normalise, round, pack ----------------
    logic [4:0]        lz;
    logic [26:0]       norm;
    logic signed [9:0] nexp, fexp;
    logic              round_up;
    logic [24:0]       rnd;
    logic [22:0]       frac;
    logic [31:0]       res_dat;

    always_comb begin
        lz = 5'd27;
        for (int i = 0; i <= 26; i++) begin
            if (mid.sum[i]) lz = 5'(26 - i);
        end
        if (mid.sum[27]) begin
            norm = {mid.sum[27:2], mid.sum[1] | mid.sum[0]};
            nexp = $signed({2'b00, mid.exp}) + 10'sd1;
        end else begin
            norm = mid.sum[26:0] << lz;
            nexp = $signed({2'b00, mid.exp}) - $signed({5'd0, lz});
        end
        round_up = norm[2] && (norm[1] || norm[0] || norm[3]);
        rnd      = {1'b0, norm[26:3]} + {24'd0, round_up};
        if (rnd[24]) begin
            fexp = nexp + 10'sd1;
            frac = rnd[23:1];
        end else begin
            fexp = nexp;
            frac = rnd[22:0];
        end

        if (mid.op != OP_FADD)      res_dat = mid.dat;
        else if (mid.nan)           res_dat = 32'h7FC0_0000;
        else if (mid.inf)           res_dat = {mid.inf_sgn, 8'hFF, 23'd0};
        else if (mid.sum == 28'd0)  res_dat = {mid.zero_sgn, 31'd0};
        else if (nexp <= 0)         res_dat = {mid.sgn, 31'd0};
        else if (fexp >= 255)       res_dat = {mid.sgn, 8'hFF, 23'd0};
        else                        res_dat = {mid.sgn, fexp[7:0], frac};
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_axis_result_tvalid <= 1'b0;
            m_axis_result_tdata  <= 32'd0;
        end else begin
            m_axis_result_tvalid <= mid_vld;
            if (mid_vld) begin
                m_axis_result_tdata <= res_dat;
            end
        end
    end

`ifdef FABS_FADD_FCMP_STATUS_EN
    logic mid_inv;
    logic fadd_fin, res_ovf, res_unf;

    always_ff @(posedge aclk) begin
        if (in_vld) begin
            mid_inv <= ((in_dat.op == OP_FADD) && mid_nxt.nan) ||
                       ((in_dat.op == OP_FCMP) && cmp_un);
        end
    end

    always_comb begin
        fadd_fin = (mid.op == OP_FADD) && !mid.nan && !mid.inf && (mid.sum != 28'd0);
        res_unf  = fadd_fin && (nexp <= 0);
        res_ovf  = fadd_fin && (nexp > 0) && (fexp >= 255);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_axis_result_tuser <= 3'b000;
        end else if (mid_vld) begin
            m_axis_result_tuser <= {mid_inv, res_ovf, res_unf};
        end
    end
`endif

endmodule

// File: tb/tb_fabs_fadd_fcmp.sv
// Bench for fabs_fadd_fcmp: directed corner beats then randomized traffic against an exact-arithmetic model.
module tb_fabs_fadd_fcmp;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [1:0]  s_axis_op;
    logic [31:0] s_axis_a_tdata;
    logic [31:0] s_axis_b_tdata;
    logic [5:0]  s_axis_operation_tdata;
    logic        m_axis_result_tvalid;
    logic [31:0] m_axis_result_tdata;
`ifdef FABS_FADD_FCMP_STATUS_EN
    logic [2:0]  m_axis_result_tuser;
`endif

    always #5 aclk = ~aclk;

    fabs_fadd_fcmp dut (
        .aclk                   (aclk),
        .aresetn                (aresetn),
        .s_axis_tvalid          (s_axis_tvalid),
        .s_axis_tready          (s_axis_tready),
        .s_axis_op              (s_axis_op),
        .s_axis_a_tdata         (s_axis_a_tdata),
        .s_axis_b_tdata         (s_axis_b_tdata),
        .s_axis_operation_tdata (s_axis_operation_tdata),
        .m_axis_result_tvalid   (m_axis_result_tvalid),
        .m_axis_result_tdata    (m_axis_result_tdata)
`ifdef FABS_FADD_FCMP_STATUS_EN
        ,
        .m_axis_result_tuser    (m_axis_result_tuser)
`endif
    );

    typedef struct {
        int          t;
        logic [34:0] r;   // {invalid, overflow, underflow, data}
    } exp_t;

    exp_t        q[$];
    int          ntests = 0;
    int          nfail  = 0;
    int          cyc    = 0;
    bit          rdy_exp = 1'b0;
    bit          chk_on  = 1'b0;
    logic [34:0] hold    = '0;

    logic [31:0] specials [0:13] = '{
        32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'hBF80_0000,
        32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h7F7F_FFFF,
        32'hFF7F_FFFF, 32'h0000_0001, 32'h8040_0000, 32'h0080_0000,
        32'h8080_0000, 32'h7F80_0001
    };

    // ---------------- reference model: exact integers in units of 2^-149 ----------------
    function automatic bit is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic bit is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic signed [299:0] fval(input logic [31:0] x);
        logic signed [299:0] m;
        m = '0;
        if (x[30:23] != 8'd0) begin
            m[23:0] = {1'b1, x[22:0]};
            m = m <<< (int'(x[30:23]) - 1);
            if (x[31]) m = -m;
        end
        return m;
    endfunction

    function automatic logic [34:0] m_fadd(input logic [31:0] a, input logic [31:0] b);
        logic signed [299:0] s;
        logic [299:0] mag, keep, rem, half;
        bit sgn;
        int p, be, sh;
        if (is_nan(a) || is_nan(b) || (is_inf(a) && is_inf(b) && (a[31] != b[31])))
            return {3'b100, 32'h7FC0_0000};
        if (is_inf(a)) return {3'b000, a};
        if (is_inf(b)) return {3'b000, b};
        s = fval(a) + fval(b);
        if (s == 0) return {3'b000, a[31] & b[31], 31'd0};
        sgn = (s < 0);
        mag = sgn ? -s : s;
        p = -1;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        if (p <= 22) return {3'b001, sgn, 31'd0};
        be = p - 22;
        if (p > 23) begin
            sh   = p - 23;
            keep = mag >> sh;
            rem  = mag & ((300'd1 << sh) - 300'd1);
            half = 300'd1 << (sh - 1);
            if ((rem > half) || ((rem == half) && keep[0])) keep = keep + 300'd1;
            if (keep[24]) begin
                keep = keep >> 1;
                be   = be + 1;
            end
        end else begin
            keep = mag << (23 - p);
        end
        if (be >= 255) return {3'b010, sgn, 8'hFF, 23'd0};
        return {3'b000, sgn, 8'(be), keep[22:0]};
    endfunction

    function automatic logic [34:0] m_fcmp(input logic [31:0] a, input logic [31:0] b,
                                           input logic [5:0] code);
        bit un, lt, eq, gt, c;
        un = is_nan(a) || is_nan(b);
        lt = 1'b0; eq = 1'b0; gt = 1'b0;
        if (!un) begin
            lt = fval(a) <  fval(b);
            eq = fval(a) == fval(b);
            gt = fval(a) >  fval(b);
        end
        case (code)
            6'b000100: c = un;
            6'b001100: c = lt;
            6'b010100: c = eq;
            6'b011100: c = lt | eq;
            6'b100100: c = gt;
            6'b101100: c = un | !eq;
            6'b110100: c = gt | eq;
            default:   c = 1'b0;
        endcase
        return {un, 2'b00, 31'd0, c};
    endfunction

    function automatic logic [34:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [5:0] code);
        case (op)
            2'b00:   return m_fadd(a, b);
            2'b01:   return {3'b000, 1'b0, a[30:0]};
            2'b10:   return m_fcmp(a, b, code);
            default: return 35'd0;
        endcase
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntests++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_outputs();
        bit ev;
        ev = 1'b0;
        if (q.size() > 0) ev = (q[0].t == cyc);
        if (ev) begin
            hold = q[0].r;
            void'(q.pop_front());
        end
        chk("tready", {31'd0, s_axis_tready}, {31'd0, rdy_exp});
        chk("tvalid", {31'd0, m_axis_result_tvalid}, {31'd0, ev});
        chk("tdata", m_axis_result_tdata, hold[31:0]);
`ifdef FABS_FADD_FCMP_STATUS_EN
        chk("tuser", {29'd0, m_axis_result_tuser}, {29'd0, hold[34:32]});
`endif
    endtask

    // One clock cycle: drive, check previous edge's outputs at negedge, book-keep the edge.
    task automatic beat(input bit v, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] code, input bit rstn);
        exp_t e;
        bit   acc;
        aresetn                = rstn;
        s_axis_tvalid          = v;
        s_axis_op              = op;
        s_axis_a_tdata         = a;
        s_axis_b_tdata         = b;
        s_axis_operation_tdata = code;
        @(negedge aclk);
        if (chk_on) check_outputs();
        acc = v && rdy_exp && rstn;
        @(posedge aclk);
        cyc++;
        if (!rstn) begin
            q.delete();
            hold    = '0;
            rdy_exp = 1'b0;
            chk_on  = 1'b1;
        end else begin
            if (acc) begin
                e.t = cyc + 2;
                e.r = model(op, a, b, code);
                q.push_back(e);
            end
            rdy_exp = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input int n, input bit rstn);
        for (int i = 0; i < n; i++) beat(1'b0, 2'b00, 32'd0, 32'd0, 6'd0, rstn);
    endtask

    initial begin
        aresetn = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_op = 2'b00;
        s_axis_a_tdata = 32'd0;
        s_axis_b_tdata = 32'd0;
        s_axis_operation_tdata = 6'd0;
        @(posedge aclk);
        #1;

        idle(3, 1'b0);
        idle(2, 1'b1);

        // fadd basics, overflow, rounding ties and specials
        beat(1'b1, 2'b00, 32'h3F80_0000, 32'h4000_0000, 6'd0, 1'b1);
        idle(3, 1'b1);
        beat(1'b1, 2'b00, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 6'd0, 1'b1);
        beat(1'b1, 2'b00, 32'h3F80_0000, 32'h3380_0000, 6'd0, 1'b1);
        beat(1'b1, 2'b00, 32'h3F80_0001, 32'h3380_0000, 6'd0, 1'b1);
        beat(1'b1, 2'b00, 32'h3F80_0000, 32'hBF80_0000, 6'd0, 1'b1);
        beat(1'b1, 2'b00, 32'h7F80_0000, 32'hFF80_0000, 6'd0, 1'b1);
        beat(1'b1, 2'b00, 32'h8000_0000, 32'h8000_0000, 6'd0, 1'b1);
        beat(1'b1, 2'b00, 32'h0080_0001, 32'h8080_0000, 6'd0, 1'b1);
        // fabs
        beat(1'b1, 2'b01, 32'hC049_0FDB, 32'd0, 6'd0, 1'b1);
        beat(1'b1, 2'b01, 32'hFFC0_0000, 32'd0, 6'd0, 1'b1);
        // fcmp
        beat(1'b1, 2'b10, 32'h3F80_0000, 32'h4000_0000, 6'b001100, 1'b1);
        beat(1'b1, 2'b10, 32'h8000_0000, 32'h0000_0000, 6'b010100, 1'b1);
        beat(1'b1, 2'b10, 32'h7FC0_0000, 32'h3F80_0000, 6'b010100, 1'b1);
        beat(1'b1, 2'b10, 32'h7FC0_0000, 32'h3F80_0000, 6'b101100, 1'b1);
        beat(1'b1, 2'b10, 32'h3F80_0000, 32'h3F80_0000, 6'b111100, 1'b1);
        // reserved op
        beat(1'b1, 2'b11, 32'hDEAD_BEEF, 32'h1234_5678, 6'b010100, 1'b1);
        idle(3, 1'b1);
        // back-to-back mixed ops
        beat(1'b1, 2'b00, 32'h4040_0000, 32'hC000_0000, 6'd0, 1'b1);
        beat(1'b1, 2'b01, 32'h8000_0001, 32'd0, 6'd0, 1'b1);
        beat(1'b1, 2'b10, 32'hBF80_0000, 32'h3F80_0000, 6'b011100, 1'b1);
        idle(4, 1'b1);
        // reset one cycle after an accepted beat
        beat(1'b1, 2'b00, 32'h3F80_0000, 32'h3F80_0000, 6'd0, 1'b1);
        idle(2, 1'b0);
        idle(4, 1'b1);

        for (int n = 0; n < 600; n++) begin
            logic [31:0] ra, rb, tmp;
            logic [1:0]  rop;
            logic [5:0]  rc;
            logic [2:0]  k3;
            bit          v, rstn;
            tmp = $urandom;
            if ($urandom_range(3) == 0) ra = specials[$urandom_range(13)];
            else ra = $urandom;
            case ($urandom_range(3))
                0:       rb = specials[$urandom_range(13)];
                1:       rb = {~ra[31], ra[30:8], ra[7:0] ^ tmp[7:0]};
                2:       rb = {tmp[31], ra[30:23] ^ {5'd0, tmp[26:24]}, tmp[22:0]};
                default: rb = $urandom;
            endcase
            rop = 2'($urandom_range(3));
            k3  = 3'($urandom_range(7));
            rc  = (k3 == 3'd7) ? 6'($urandom) : {k3, 3'b100};
            v    = ($urandom_range(4) != 0);
            rstn = !(n >= 300 && n < 302);
            beat(v, rop, ra, rb, rc, rstn);
        end
        idle(5, 1'b1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
